dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate data-cache controller. It sits between the EX_MEM pipeline register and the 256-bit data memory, and holds the tag array (valid, dirty, tag) and the data array. It serves CPU loads and stores in zero extra cycles on a hit. On a miss it sequences the dirty-line writeback and the line refill, and drives the stall that freezes PC, IF_ID, ID_EX, EX_MEM and MEM_WB.

---
 rtl/dcache_controller.sv | 117 +++++++++++
 tb/tb_dcache_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped write-back / write-allocate data cache controller.
// Hits complete with no extra cycles; misses run writeback + refill against a 256-bit line memory.
module dcache_controller #(
  parameter int LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - IW - 5;

  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, READMISSOK} state_t;
  state_t state;

  logic [LINES-1:0] valid_q, dirty_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [255:0]     data_q [LINES];

  logic [TW-1:0]  req_tag;
  logic [IW-1:0]  idx;
  logic [2:0]     word;
  logic           req, hit, idle;
  logic [255:0]   line;
  logic           unused_addr_lsb;

  assign req_tag = p1_addr_i[31:5+IW];
  assign idx     = p1_addr_i[5+IW-1:5];
  assign word    = p1_addr_i[4:2];
  assign unused_addr_lsb = ^p1_addr_i[1:0];
  assign req     = p1_MemRead_i | p1_MemWrite_i;
  assign line    = data_q[idx];
  assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);
  assign idle    = (state == IDLE);

  // Both CPU-facing outputs are held at 0 while reset is asserted.
  assign p1_stall_o = rst_i && (!idle || (req && !hit));
  assign p1_data_o  = (rst_i && idle && hit) ? line[{word, 5'b0} +: 32] : 32'd0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            if (p1_MemWrite_i) dirty_q[idx] <= 1'b1;
          end else if (req) begin
            state <= MISS;
          end
        end
        MISS: begin
          mem_enable_o <= 1'b1;
          if (valid_q[idx] && dirty_q[idx]) begin
            state       <= WRITEBACK;
            mem_write_o <= 1'b1;
            mem_addr_o  <= {tag_q[idx], idx, 5'b0};
            mem_data_o  <= line;
          end else begin
            state       <= READMISS;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {req_tag, idx, 5'b0};
          end
        end
        WRITEBACK: begin
          // Enable stays high; the memory sees a fresh read request after the ack.
          if (mem_ack_i) begin
            state       <= READMISS;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {req_tag, idx, 5'b0};
            mem_data_o  <= '0;
          end
        end
        READMISS: begin
          if (mem_ack_i) begin
            state        <= READMISSOK;
            mem_enable_o <= 1'b0;
            mem_addr_o   <= '0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end
        end
        READMISSOK: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays are not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (state == READMISS && mem_ack_i) begin
        data_q[idx] <= mem_data_i;
        tag_q[idx]  <= req_tag;
      end else if (idle && req && hit && p1_MemWrite_i) begin
        data_q[idx][{word, 5'b0} +: 32] <= p1_data_i;
      end
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Randomized + directed bench for dcache_controller against a flat-memory reference model.
module tb_dcache_controller;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  p1_addr = '0, p1_data = '0;
  logic         p1_rd = 1'b0, p1_wr = 1'b0;
  logic [31:0]  p1_data_o, mem_addr_o;
  logic         p1_stall_o, mem_enable_o, mem_write_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_rdata = '0;
  logic         resp_ack = 1'b0, man_ack = 1'b0, mem_ack;
  assign mem_ack = resp_ack | man_ack;

  bit resp_on = 1'b1;
  int lat = 10, resp_cnt = 0;
  int errs = 0, checks = 0;

  logic [255:0] bmem     [logic [26:0]];
  logic [31:0]  ref_word [logic [29:0]];
  logic [31:0]  wb_a[$], rd_a[$];
  logic [255:0] wb_d[$];
  bit           res_v[32], res_d[32];
  logic [21:0]  res_tag[32];

  dcache_controller #(.LINES(32)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .p1_addr_i(p1_addr), .p1_data_i(p1_data),
    .p1_MemRead_i(p1_rd), .p1_MemWrite_i(p1_wr),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  function automatic logic [255:0] mem_line(input logic [26:0] la);
    logic [255:0] ln;
    if (bmem.exists(la)) return bmem[la];
    for (int w = 0; w < 8; w++) ln[w*32 +: 32] = init_word({la, w[2:0], 2'b00});
    return ln;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [255:0] ln;
    if (ref_word.exists(a[31:2])) return ref_word[a[31:2]];
    ln = mem_line(a[31:5]);
    return ln[{a[4:2], 5'b0} +: 32];
  endfunction

  // Memory: ack after lat cycles of enable, one-cycle pulse.
  always @(negedge clk) begin
    logic [26:0] la;
    if (resp_ack) resp_ack = 1'b0;
    if (!resp_on) resp_cnt = 0;
    else if (mem_enable_o) begin
      resp_cnt++;
      if (resp_cnt >= lat) begin
        resp_cnt = 0;
        resp_ack = 1'b1;
        la = mem_addr_o[31:5];
        if (mem_write_o) begin
          bmem[la] = mem_data_o;
          wb_a.push_back(mem_addr_o);
          wb_d.push_back(mem_data_o);
        end else begin
          mem_rdata = mem_line(la);
          rd_a.push_back(mem_addr_o);
        end
      end
    end
  end

  // One CPU access; called at a negedge, returns at the following negedge.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input bit wr);
    logic [4:0]   idx;
    logic [21:0]  tg;
    logic [255:0] exp_line;
    bit           hit, dty;
    int           exp_st, cyc;
    idx = a[9:5];
    tg  = a[31:10];
    hit = res_v[idx] && (res_tag[idx] == tg);
    dty = !hit && res_v[idx] && res_d[idx];
    exp_st = hit ? 0 : (dty ? 2*lat + 3 : lat + 3);
    for (int w = 0; w < 8; w++) exp_line[w*32 +: 32] = ref_rd({res_tag[idx], idx, w[2:0], 2'b00});
    wb_a.delete(); wb_d.delete(); rd_a.delete();
    p1_addr = a; p1_data = d; p1_wr = wr; p1_rd = !wr;
    #1;
    cyc = 0;
    while (p1_stall_o && cyc < 300) begin
      cyc++;
      @(negedge clk); #1;
    end
    chk("stall_cycles", 256'(cyc), 256'(exp_st));
    if (!wr) chk("load_data", 256'(p1_data_o), 256'(ref_rd(a)));
    chk("refill_count", 256'(rd_a.size()), 256'(hit ? 0 : 1));
    if (!hit && rd_a.size() == 1) chk("refill_addr", 256'(rd_a[0]), 256'({a[31:5], 5'b0}));
    chk("wb_count", 256'(wb_a.size()), 256'(dty ? 1 : 0));
    if (dty && wb_a.size() == 1) begin
      chk("wb_addr", 256'(wb_a[0]), 256'({res_tag[idx], idx, 5'b0}));
      chk("wb_line", wb_d[0], exp_line);
    end
    if (!hit) begin res_v[idx] = 1'b1; res_tag[idx] = tg; res_d[idx] = 1'b0; end
    if (wr) begin res_d[idx] = 1'b1; ref_word[a[31:2]] = d; end
    @(negedge clk);
    p1_rd = 1'b0; p1_wr = 1'b0;
  endtask

  initial begin
    logic [255:0] ln;
    logic [31:0]  ra;
    int           cyc;
    ln = mem_line(27'h2);
    ln[127:96] = 32'hDEADBEEF;
    bmem[27'h2] = ln;

    // Reset: outputs quiet
    repeat (2) begin
      @(negedge clk);
      chk("rst_stall", 256'(p1_stall_o), 256'(0));
      chk("rst_data", 256'(p1_data_o), 256'(0));
      chk("rst_en", 256'(mem_enable_o), 256'(0));
      chk("rst_wr", 256'(mem_write_o), 256'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);

    access(32'h0000_0040, 32'h0, 1'b0);                 // clean miss, L+3
    access(32'h0000_004C, 32'h0, 1'b0);
    chk("deadbeef", 256'(ref_rd(32'h4C)), 256'(32'hDEADBEEF));
    access(32'h0000_0048, 32'h0, 1'b0);
    access(32'h0000_004C, 32'h1234_5678, 1'b1);         // store hit
    access(32'h0000_004C, 32'h0, 1'b0);
    access(32'h0000_044C, 32'h0, 1'b0);                 // dirty eviction, 2L+3
    if (wb_d.size() == 1) begin
      ln = wb_d[0];
      chk("evict_word3", 256'(ln[127:96]), 256'(32'h1234_5678));
    end else chk("evict_present", 256'(wb_d.size()), 256'(1));
    access(32'h0000_0080, 32'hAAAA_5555, 1'b1);         // store miss
    access(32'h0000_0084, 32'h0, 1'b0);
    access(32'h0000_0480, 32'h0, 1'b0);                 // evicts index 4
    if (wb_d.size() == 1) begin
      ln = wb_d[0];
      chk("evict_word0", 256'(ln[31:0]), 256'(32'hAAAA_5555));
    end else chk("evict4_present", 256'(wb_d.size()), 256'(1));

    // Random traffic over a small address pool to force conflicts
    for (int i = 0; i < 200; i++) begin
      lat = $urandom_range(1, 5);
      ra  = {20'h0, 2'($urandom_range(0, 3)), 2'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
      access(ra, $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset during READMISS, then a stray ack
    lat = 10;
    resp_on = 1'b0;
    p1_addr = 32'h00F0_0100; p1_rd = 1'b1;
    cyc = 0;
    while (!mem_enable_o && cyc < 20) begin @(negedge clk); cyc++; end
    chk("rm_enable", 256'(mem_enable_o), 256'(1));
    chk("rm_is_read", 256'(mem_write_o), 256'(0));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm_drop_en", 256'(mem_enable_o), 256'(0));
    chk("rm_stall_rst", 256'(p1_stall_o), 256'(0));
    p1_rd = 1'b0;
    rst_n = 1'b1;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    chk("rm_ack_ignored", 256'(mem_enable_o), 256'(0));
    @(negedge clk);
    chk("rm_idle_en", 256'(mem_enable_o), 256'(0));
    chk("rm_idle_stall", 256'(p1_stall_o), 256'(0));
    ref_word.delete();
    for (int i = 0; i < 32; i++) res_v[i] = 1'b0;
    resp_on = 1'b1;
    access(32'h00F0_0100, 32'h0, 1'b0);
    access(32'h0000_004C, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
